led_frame_buffer: RTL and testbench

Double-buffered grayscale store sitting directly upstream of the pixel driver that shifts data into the TLC-style LED driver chains (6 left, 6 right). The host side writes 12-bit grayscale values into the back bank through a valid/ready port. The driver side reads one channel slot for all chains in parallel from the front bank. Banks swap only on a frame boundary signalled by the driver, so a displayed frame is never torn.

---
 rtl/nx4_led_pkg.sv | 13 +
 rtl/led_frame_buffer_if.sv | 36 +++
 rtl/led_gamma_expand.sv | 14 +
 rtl/led_frame_buffer.sv | 136 +++++++++++++
 tb/tb_led_frame_buffer.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/nx4_led_pkg.sv
// Shared constants and swap-FSM state type for the LED driver front end.
package nx4_led_pkg;

  localparam int GS_BITS           = 12;
  localparam int CHANNELS_PER_CHIP = 16;
  localparam int FRAME_CNT_W       = 10;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } swap_state_t;

endpackage

// File: rtl/led_frame_buffer_if.sv
// Host write port, driver read port and bank-swap handshake of the LED frame buffer.
interface led_frame_buffer_if
  import nx4_led_pkg::*;
#(
  parameter int CHAINS  = 12,
  parameter int SLOT_W  = 4,
  parameter int CHAIN_W = 4
);

  logic                      wr_valid;
  logic                      wr_ready;
  logic [CHAIN_W-1:0]        wr_chain;
  logic [SLOT_W-1:0]         wr_slot;
  logic [GS_BITS-1:0]        wr_data;
  logic                      wr_err;
  logic                      swap_req;
  logic                      swap_pending;
  logic                      swap_done;
  logic                      frame_sync;
  logic                      rd_en;
  logic [SLOT_W-1:0]         rd_slot;
  logic [CHAINS*GS_BITS-1:0] rd_data;
  logic                      front_bank;
  logic [FRAME_CNT_W-1:0]    frame_count;

  modport master (
    output wr_valid, wr_chain, wr_slot, wr_data, swap_req, frame_sync, rd_en, rd_slot,
    input  wr_ready, wr_err, swap_pending, swap_done, rd_data, front_bank, frame_count
  );

  modport slave (
    input  wr_valid, wr_chain, wr_slot, wr_data, swap_req, frame_sync, rd_en, rd_slot,
    output wr_ready, wr_err, swap_pending, swap_done, rd_data, front_bank, frame_count
  );

endinterface

// File: rtl/led_gamma_expand.sv
// 8-bit to 12-bit square-law grayscale map: dout = (din*din) >> 4.
module led_gamma_expand
  import nx4_led_pkg::*;
(
  input  logic [7:0]         din,
  output logic [GS_BITS-1:0] dout
);

  logic [15:0] square_s;

  assign square_s = {8'd0, din} * {8'd0, din};
  assign dout     = square_s[15:4];

endmodule

// File: rtl/led_frame_buffer.sv
// Double-buffered grayscale store feeding the LED chain shifters; banks swap only at frame_sync.
// Build option LED_FB_GAMMA_EN: square-law expand wr_data[7:0] before storage.
module led_frame_buffer
  import nx4_led_pkg::*;
#(
  parameter int CHAINS  = 12,
  parameter int CHIPS   = 1,
  parameter int SLOT_W  = 4,
  parameter int CHAIN_W = 4
) (
  input  logic               clock,
  input  logic               reset,
  led_frame_buffer_if.slave  bus
);

  localparam int               SLOTS     = CHIPS * CHANNELS_PER_CHIP;
  localparam logic [SLOT_W:0]  SLOT_LIM  = SLOTS[SLOT_W:0];
  localparam logic [CHAIN_W:0] CHAIN_LIM = CHAINS[CHAIN_W:0];

  logic [GS_BITS-1:0]        mem_r [0:1][0:SLOTS-1][0:CHAINS-1];
  swap_state_t               state_r;
  swap_state_t               state_nxt_s;
  logic                      swap_s;
  logic                      front_bank_r;
  logic                      wr_ready_r;
  logic                      wr_err_r;
  logic                      swap_done_r;
  logic [FRAME_CNT_W-1:0]    frame_count_r;
  logic [CHAINS*GS_BITS-1:0] rd_data_r;
  logic [CHAINS*GS_BITS-1:0] rd_word_s;
  logic                      wr_fire_s;
  logic                      wr_addr_ok_s;
  logic                      rd_addr_ok_s;
  logic [GS_BITS-1:0]        wr_value_s;

`ifdef LED_FB_GAMMA_EN
  led_gamma_expand u_gamma (
    .din  (bus.wr_data[7:0]),
    .dout (wr_value_s)
  );
`else
  assign wr_value_s = bus.wr_data;
`endif

  // Out-of-range writes are still accepted so the host never stalls on a bad address.
  assign wr_fire_s    = bus.wr_valid && wr_ready_r;
  assign wr_addr_ok_s = ({1'b0, bus.wr_slot} < SLOT_LIM) && ({1'b0, bus.wr_chain} < CHAIN_LIM);
  assign rd_addr_ok_s = ({1'b0, bus.rd_slot} < SLOT_LIM);

  // Swap FSM next state: a request coinciding with frame_sync swaps without pending.
  always_comb begin
    state_nxt_s = state_r;
    swap_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.swap_req && bus.frame_sync) begin
          swap_s      = 1'b1;
          state_nxt_s = IDLE;
        end else if (bus.swap_req) begin
          state_nxt_s = PENDING;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      PENDING: begin
        if (bus.frame_sync) begin
          swap_s      = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = PENDING;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Control registers: FSM state, bank select, handshake flags and frame counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r       <= IDLE;
      front_bank_r  <= 1'b0;
      wr_ready_r    <= 1'b1;
      wr_err_r      <= 1'b0;
      swap_done_r   <= 1'b0;
      frame_count_r <= '0;
    end else begin
      state_r      <= state_nxt_s;
      front_bank_r <= front_bank_r ^ swap_s;
      wr_ready_r   <= (state_nxt_s != PENDING);
      wr_err_r     <= wr_fire_s && !wr_addr_ok_s;
      swap_done_r  <= swap_s;
      if (bus.frame_sync) begin
        frame_count_r <= frame_count_r + FRAME_CNT_W'(1'b1);
      end else begin
        frame_count_r <= frame_count_r;
      end
    end
  end

  // Back-bank write; bank select is pre-swap, so a write in the swap cycle lands in the old back bank.
  always_ff @(posedge clock) begin
    if (wr_fire_s && wr_addr_ok_s) begin
      mem_r[~front_bank_r][bus.wr_slot][bus.wr_chain] <= wr_value_s;
    end
  end

  // Gather one slot across all chains from the front bank.
  always_comb begin
    rd_word_s = '0;
    for (int k = 0; k < CHAINS; k++) begin
      rd_word_s[k*GS_BITS +: GS_BITS] = rd_addr_ok_s ? mem_r[front_bank_r][bus.rd_slot][k] : '0;
    end
  end

  // Registered read word, held while rd_en is low.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_data_r <= '0;
    end else if (bus.rd_en) begin
      rd_data_r <= rd_word_s;
    end else begin
      rd_data_r <= rd_data_r;
    end
  end

  assign bus.wr_ready     = wr_ready_r;
  assign bus.wr_err       = wr_err_r;
  assign bus.swap_pending = (state_r == PENDING);
  assign bus.swap_done    = swap_done_r;
  assign bus.front_bank   = front_bank_r;
  assign bus.frame_count  = frame_count_r;
  assign bus.rd_data      = rd_data_r;

endmodule

// File: tb/tb_led_frame_buffer.sv
// Self-checking bench for led_frame_buffer: reference model + scoreboard, vector table, corner sequences.
module tb_led_frame_buffer;
  import nx4_led_pkg::*;

  localparam int CHAINS = 12;
  localparam int SLOTS  = 16;
  localparam int RW     = CHAINS * 12;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  led_frame_buffer_if #(.CHAINS(CHAINS), .SLOT_W(4), .CHAIN_W(4)) bus ();

  led_frame_buffer #(.CHAINS(CHAINS), .CHIPS(1), .SLOT_W(4), .CHAIN_W(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [RW-1:0] rd;
    logic          ready;
    logic          err;
    logic          pend;
    logic          done;
    logic          front;
    logic [9:0]    fc;
  } exp_t;

  typedef struct {
    logic        wv;
    logic [3:0]  ch;
    logic [3:0]  sl;
    logic [11:0] d;
    logic        sr;
    logic        fs;
    logic        re;
    logic [3:0]  rs;
    logic        e_ready;
    logic        e_err;
    logic        e_pend;
    logic        e_done;
    logic        e_front;
    logic        chk;
    int          chk_ch;
    logic [11:0] chk_raw;
  } vec_t;

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  logic [11:0]   m_mem [0:1][0:SLOTS-1][0:CHAINS-1];
  logic          m_front, m_pend, m_done, m_err, m_ready;
  logic [9:0]    m_fc;
  logic [RW-1:0] m_rd;

  vec_t        vecs[14];
  logic [9:0]  fc_start;
  logic [11:0] exp_g;

  function automatic logic [11:0] gam(input logic [11:0] d);
`ifdef LED_FB_GAMMA_EN
    logic [15:0] sq;
    sq = {8'd0, d[7:0]} * {8'd0, d[7:0]};
    return sq[15:4];
`else
    return d;
`endif
  endfunction

  task automatic chk(input string name, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_front = 1'b0; m_pend = 1'b0; m_done = 1'b0; m_err = 1'b0;
    m_ready = 1'b1; m_fc = 10'd0; m_rd = '0;
  endtask

  // Drive one cycle at negedge, predict, then check every output at the following negedge.
  task automatic step(input logic wv, input logic [3:0] ch, input logic [3:0] sl, input logic [11:0] d,
                      input logic sr, input logic fs, input logic re, input logic [3:0] rs);
    exp_t e;
    logic acc;
    bus.wr_valid = wv; bus.wr_chain = ch; bus.wr_slot = sl; bus.wr_data = d;
    bus.swap_req = sr; bus.frame_sync = fs; bus.rd_en = re; bus.rd_slot = rs;
    acc = wv && m_ready;
    if (re) begin
      for (int k = 0; k < CHAINS; k++) m_rd[k*12 +: 12] = m_mem[m_front][rs][k];
    end
    if (acc && (ch < 4'd12)) m_mem[~m_front][sl][ch] = gam(d);
    m_err  = acc && !(ch < 4'd12);
    m_done = 1'b0;
    if (!m_pend) begin
      if (sr && fs) begin
        m_front = ~m_front; m_done = 1'b1;
      end else if (sr) begin
        m_pend = 1'b1;
      end
    end else if (fs) begin
      m_front = ~m_front; m_done = 1'b1; m_pend = 1'b0;
    end
    if (fs) m_fc = m_fc + 10'd1;
    m_ready = !m_pend;
    e = '{m_rd, m_ready, m_err, m_pend, m_done, m_front, m_fc};
    sb.push_back(e);
    @(negedge clock);
    e = sb.pop_front();
    chk("rd_data",      bus.rd_data, e.rd);
    chk("wr_ready",     RW'(bus.wr_ready), RW'(e.ready));
    chk("wr_err",       RW'(bus.wr_err), RW'(e.err));
    chk("swap_pending", RW'(bus.swap_pending), RW'(e.pend));
    chk("swap_done",    RW'(bus.swap_done), RW'(e.done));
    chk("front_bank",   RW'(bus.front_bank), RW'(e.front));
    chk("frame_count",  RW'(bus.frame_count), RW'(e.fc));
  endtask

  task automatic idle();
    step(1'b0, 4'd0, 4'd0, 12'd0, 1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 4'd12, 4'd0, 12'hFFF, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 12'h000};
    vecs[1]  = '{1'b0, 4'd0,  4'd0, 12'h000, 1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 12'h000};
    vecs[2]  = '{1'b1, 4'd1,  4'd2, 12'h123, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 12'h000};
    vecs[3]  = '{1'b1, 4'd4,  4'd2, 12'h456, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 12'h000};
    vecs[4]  = '{1'b0, 4'd0,  4'd0, 12'h000, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 12'h000};
    vecs[5]  = '{1'b0, 4'd0,  4'd0, 12'h000, 1'b0, 1'b1, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1, 12'h821};
    vecs[6]  = '{1'b0, 4'd0,  4'd0, 12'h000, 1'b0, 1'b0, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 12'h123};
    vecs[7]  = '{1'b0, 4'd0,  4'd0, 12'h000, 1'b0, 1'b0, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4, 12'h024};
    vecs[8]  = '{1'b0, 4'd0,  4'd0, 12'h000, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 12'h000};
    vecs[9]  = '{1'b1, 4'd7,  4'd9, 12'h9A5, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 12'h000};
    vecs[10] = '{1'b0, 4'd0,  4'd0, 12'h000, 1'b0, 1'b0, 1'b1, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 7, 12'h9A5};
    vecs[11] = '{1'b1, 4'd0,  4'd0, 12'h0FF, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 12'h000};
    vecs[12] = '{1'b1, 4'd1,  4'd3, 12'hF10, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 12'h000};
    vecs[13] = '{1'b0, 4'd0,  4'd0, 12'h000, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 7, 12'h9A5};

    reset = 1'b1;
    bus.wr_valid = 1'b0; bus.wr_chain = 4'd0; bus.wr_slot = 4'd0; bus.wr_data = 12'd0;
    bus.swap_req = 1'b0; bus.frame_sync = 1'b0; bus.rd_en = 1'b0; bus.rd_slot = 4'd0;
    model_reset();
    repeat (2) @(negedge clock);
    chk("reset_rd_data",   bus.rd_data, '0);
    chk("reset_wr_ready",  RW'(bus.wr_ready), RW'(1'b1));
    chk("reset_wr_err",    RW'(bus.wr_err), RW'(1'b0));
    chk("reset_pending",   RW'(bus.swap_pending), RW'(1'b0));
    chk("reset_done",      RW'(bus.swap_done), RW'(1'b0));
    chk("reset_front",     RW'(bus.front_bank), RW'(1'b0));
    chk("reset_fcount",    RW'(bus.frame_count), RW'(10'd0));
    reset = 1'b0;

    // Fill bank 1 (back after reset), with chain 3 slot 5 = 0xABC.
    for (int s = 0; s < SLOTS; s++)
      for (int c = 0; c < CHAINS; c++)
        step(1'b1, 4'(c), 4'(s), {1'b1, 3'b000, 4'(s), 4'(c)}, 1'b0, 1'b0, 1'b0, 4'd0);
    step(1'b1, 4'd3, 4'd5, 12'hABC, 1'b0, 1'b0, 1'b0, 4'd0);
    step(1'b0, 4'd0, 4'd0, 12'd0, 1'b1, 1'b1, 1'b0, 4'd0);
    chk("first_swap_done",  RW'(bus.swap_done), RW'(1'b1));
    chk("first_swap_front", RW'(bus.front_bank), RW'(1'b1));
    step(1'b0, 4'd0, 4'd0, 12'd0, 1'b0, 1'b0, 1'b1, 4'd5);
    chk("abc_chain3", RW'(bus.rd_data[47:36]), RW'(gam(12'hABC)));
    chk("done_once",  RW'(bus.swap_done), RW'(1'b0));

    // Fill bank 0 (now back).
    for (int s = 0; s < SLOTS; s++)
      for (int c = 0; c < CHAINS; c++)
        step(1'b1, 4'(c), 4'(s), {1'b0, 3'b000, 4'(s), 4'(c)}, 1'b0, 1'b0, 1'b0, 4'd0);

    // Vector table: control outputs hand-derived, rd_data via scoreboard.
    for (int i = 0; i < 14; i++) begin
      step(vecs[i].wv, vecs[i].ch, vecs[i].sl, vecs[i].d, vecs[i].sr, vecs[i].fs, vecs[i].re, vecs[i].rs);
      chk($sformatf("vec%0d_ready", i), RW'(bus.wr_ready), RW'(vecs[i].e_ready));
      chk($sformatf("vec%0d_err", i),   RW'(bus.wr_err), RW'(vecs[i].e_err));
      chk($sformatf("vec%0d_pend", i),  RW'(bus.swap_pending), RW'(vecs[i].e_pend));
      chk($sformatf("vec%0d_done", i),  RW'(bus.swap_done), RW'(vecs[i].e_done));
      chk($sformatf("vec%0d_front", i), RW'(bus.front_bank), RW'(vecs[i].e_front));
      if (vecs[i].chk)
        chk($sformatf("vec%0d_chain%0d", i, vecs[i].chk_ch),
            RW'(bus.rd_data[vecs[i].chk_ch*12 +: 12]), RW'(gam(vecs[i].chk_raw)));
    end

    // Bring bank 0 to front and read it all back, including the slot hit by the dropped write.
    step(1'b0, 4'd0, 4'd0, 12'd0, 1'b1, 1'b1, 1'b0, 4'd0);
    for (int s = 0; s < SLOTS; s++) step(1'b0, 4'd0, 4'd0, 12'd0, 1'b0, 1'b0, 1'b1, 4'(s));
    step(1'b0, 4'd0, 4'd0, 12'd0, 1'b0, 1'b0, 1'b1, 4'd0);
`ifdef LED_FB_GAMMA_EN
    exp_g = 12'hFE0;
`else
    exp_g = 12'h0FF;
`endif
    chk("store_0ff", RW'(bus.rd_data[11:0]), RW'(exp_g));
    step(1'b0, 4'd0, 4'd0, 12'd0, 1'b0, 1'b0, 1'b1, 4'd3);
`ifdef LED_FB_GAMMA_EN
    exp_g = 12'h010;
`else
    exp_g = 12'hF10;
`endif
    chk("store_f10", RW'(bus.rd_data[23:12]), RW'(exp_g));

    // 1024 frame_sync pulses without a request: counter wraps, bank stays.
    fc_start = m_fc;
    for (int i = 0; i < 1024; i++) begin
      step(1'b0, 4'd0, 4'd0, 12'd0, 1'b0, 1'b1, 1'b0, 4'd0);
      idle();
    end
    chk("fc_wrap",  RW'(bus.frame_count), RW'(fc_start));
    chk("fc_front", RW'(bus.front_bank), RW'(1'b0));

    // Reset while a swap is pending discards the request.
    step(1'b0, 4'd0, 4'd0, 12'd0, 1'b1, 1'b0, 1'b0, 4'd0);
    chk("pend_before_reset", RW'(bus.swap_pending), RW'(1'b1));
    reset = 1'b1;
    #1;
    model_reset();
    chk("midreset_pending", RW'(bus.swap_pending), RW'(1'b0));
    chk("midreset_ready",   RW'(bus.wr_ready), RW'(1'b1));
    chk("midreset_front",   RW'(bus.front_bank), RW'(1'b0));
    chk("midreset_fcount",  RW'(bus.frame_count), RW'(10'd0));
    @(negedge clock);
    reset = 1'b0;
    step(1'b0, 4'd0, 4'd0, 12'd0, 1'b0, 1'b1, 1'b0, 4'd0);
    chk("no_swap_after_reset", RW'(bus.front_bank), RW'(1'b0));
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
